uart_rx_fifo: RTL and testbench

Buffered UART receiver for the RV32 SoC top level. It replaces the single-character receive register behind the memory-mapped UART data word with a full receive path: input synchroniser, oversampled 8N1 deserialiser, and a small FIFO. The bus side pops one byte per read of the UART data address. The block sits between the `uart_rx` pin and the top-level read-data mux, and its status bits feed the UART status word.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/uart_rx_fifo.sv | 133 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART receive path: FSM encoding,
// register map offsets and status-word bit positions.
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } rx_state_t;

    localparam logic [7:0] UART_DATA_OFS   = 8'h04;
    localparam logic [7:0] UART_STATUS_OFS = 8'h10;

    localparam int STAT_TX_IDLE   = 0;
    localparam int STAT_NOT_EMPTY = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME_ERR = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and a registered read port.
// A pop on an empty FIFO returns zero; there is no write-to-read bypass.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             not_empty
);

    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [DEPTH_LOG2:0] wptr;
    logic [DEPTH_LOG2:0] rptr;
    logic [WIDTH-1:0]    mem [2**DEPTH_LOG2];
    logic                do_push;
    logic                do_pop;

    assign not_empty = (wptr != rptr);
    assign full      = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                       (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && not_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            rdata <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
            if (pop)     rdata <= not_empty ? mem[rptr[DEPTH_LOG2-1:0]] : '0;
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers alone
    // define which entries are valid, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[DEPTH_LOG2-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Buffered UART receiver: two-flop synchroniser, oversampled 8N1
// deserialiser and a receive FIFO popped by bus reads of the data word.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLOCK_DIV  = 104,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    input  logic       pop,
    input  logic       clear_err,
    output logic [7:0] rdata,
    output logic       not_empty,
    output logic       full,
    output logic       overrun,
    output logic       frame_err
);

    localparam int CW = $clog2(CLOCK_DIV);
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLOCK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLOCK_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = 1;

    logic            rx_meta;
    logic            rx_s;
    rx_state_t       state;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      shreg;
    logic            stop_ok;
    logic            push;
    logic            drop;

    // Synchroniser resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    assign stop_ok = (state == STOP) && (cnt == '0) && rx_s;
    assign push    = stop_ok && (!full || pop);
    assign drop    = stop_ok && full && !pop;

    // NOTE: all state here is updated with non-blocking assignments so every
    // branch reads the pre-edge values of cnt, idx and shreg.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_IDLE;
            cnt       <= CNT_BIT;
            idx       <= '0;
            shreg     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // A setting event later in this block overrides the clear.
            if (clear_err) begin
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            if (drop) overrun <= 1'b1;

            case (state)
                WAIT_IDLE: begin
                    if (!rx_s)            cnt   <= CNT_BIT;
                    else if (cnt == '0)   state <= IDLE;
                    else                  cnt   <= cnt - CNT_ONE;
                end
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= CNT_HALF;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (rx_s) begin
                        state <= IDLE;
                    end else begin
                        state <= DATA;
                        cnt   <= CNT_BIT;
                        idx   <= '0;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= CNT_BIT;
                        if (idx == 3'd7) state <= STOP;
                        else             idx   <= idx + 3'd1;
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (rx_s) begin
                        state <= IDLE;
                    end else begin
                        // Line held low: wait for a full idle bit before hunting again.
                        state     <= WAIT_IDLE;
                        cnt       <= CNT_BIT;
                        frame_err <= 1'b1;
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .wdata     (shreg),
        .rdata     (rdata),
        .full      (full),
        .not_empty (not_empty)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames are driven bit by bit on the
// falling clock edge and every output is sampled on the falling edge.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int CLOCK_DIV = 104;
    // Falling-edge index (from the start-bit drive) just after the stop sample.
    localparam int STOP_K = CLOCK_DIV / 2 + 9 * CLOCK_DIV + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       pop = 1'b0;
    logic       clear_err = 1'b0;
    logic [7:0] rdata;
    logic       not_empty;
    logic       full;
    logic       overrun;
    logic       frame_err;

    int          total = 0;
    int          bad = 0;
    logic        ne_pre;
    logic        ne_post;
    logic [11:0] snap_out;
    logic [2:0]  snap_state;

    uart_rx_fifo #(.CLOCK_DIV(CLOCK_DIV), .DEPTH_LOG2(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .pop       (pop),
        .clear_err (clear_err),
        .rdata     (rdata),
        .not_empty (not_empty),
        .full      (full),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    task automatic pop_check(input logic [7:0] exp, input string tag);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        check(tag, 32'(rdata), 32'(exp));
    endtask

    // Drives one full 10-bit frame; optionally pops or resets at a given
    // falling-edge index and snapshots outputs around those points.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int pop_at, input int rst_at);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int k = 0; k < 10 * CLOCK_DIV; k++) begin
            if (k == STOP_K - 1) ne_pre = not_empty;
            if (k == STOP_K)     ne_post = not_empty;
            if (rst_at >= 0 && k == rst_at + 2) begin
                snap_out   = {rdata, not_empty, full, overrun, frame_err};
                snap_state = dut.state;
            end
            uart_rx = bits[k / CLOCK_DIV];
            pop     = (k == pop_at);
            rst     = (rst_at >= 0) && (k == rst_at || k == rst_at + 1);
            @(negedge clk);
        end
        pop = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        uart_rx = 1'b1;
        idle(3);
        check("rst_rdata", 32'(rdata), 32'h00);
        check("rst_not_empty", 32'(not_empty), 32'h0);
        check("rst_full", 32'(full), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_state", 32'(dut.state), 32'(WAIT_IDLE));
        rst = 1'b0;
        idle(200);
        check("idle_after_rst", 32'(dut.state), 32'(IDLE));

        // Single byte with exact not_empty timing
        send_frame(8'h55, 1'b1, -1, -1);
        check("single_ne_before_stop", 32'(ne_pre), 32'h0);
        check("single_ne_after_stop", 32'(ne_post), 32'h1);
        pop_check(8'h55, "single_rdata");
        check("single_empty_after_pop", 32'(not_empty), 32'h0);

        // Glitch rejection
        uart_rx = 1'b0;
        idle(30);
        uart_rx = 1'b1;
        idle(100);
        check("glitch_no_push", 32'(not_empty), 32'h0);
        check("glitch_no_frame_err", 32'(frame_err), 32'h0);
        check("glitch_state", 32'(dut.state), 32'(IDLE));

        // Overrun: nine bytes into an eight-entry FIFO
        for (int b = 1; b <= 9; b++) begin
            send_frame(8'(b), 1'b1, -1, -1);
            if (b == 8) begin
                check("ovr_full_at_8", 32'(full), 32'h1);
                check("ovr_clean_at_8", 32'(overrun), 32'h0);
            end
        end
        check("ovr_full_at_9", 32'(full), 32'h1);
        check("ovr_flag", 32'(overrun), 32'h1);
        for (int i = 1; i <= 8; i++) pop_check(8'(i), $sformatf("ovr_pop_%0d", i));
        check("ovr_drained", 32'(not_empty), 32'h0);
        pop_check(8'h00, "empty_pop_zero");
        pulse_clear();
        check("ovr_cleared", 32'(overrun), 32'h0);

        // Push/pop collision while full
        for (int b = 1; b <= 8; b++) send_frame(8'(b), 1'b1, -1, -1);
        check("col_full_before", 32'(full), 32'h1);
        send_frame(8'hA5, 1'b1, STOP_K - 1, -1);
        check("col_rdata", 32'(rdata), 32'h01);
        check("col_no_overrun", 32'(overrun), 32'h0);
        check("col_still_full", 32'(full), 32'h1);
        for (int i = 2; i <= 8; i++) pop_check(8'(i), $sformatf("col_pop_%0d", i));
        pop_check(8'hA5, "col_last_a5");
        check("col_drained", 32'(not_empty), 32'h0);

        // Framing error with line held low afterwards
        send_frame(8'h3C, 1'b0, -1, -1);
        idle(300);
        check("fe_flag", 32'(frame_err), 32'h1);
        check("fe_no_push", 32'(not_empty), 32'h0);
        check("fe_wait_idle", 32'(dut.state), 32'(WAIT_IDLE));
        uart_rx = 1'b1;
        idle(50);
        check("fe_still_waiting", 32'(dut.state), 32'(WAIT_IDLE));
        idle(100);
        check("fe_back_idle", 32'(dut.state), 32'(IDLE));
        pulse_clear();
        check("fe_cleared", 32'(frame_err), 32'h0);

        // Reset during data bit 3 with two bytes queued
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, -1, -1);
        send_frame(8'h33, 1'b1, -1, -1);
        pop_check(8'h11, "mid_pre_pop");
        send_frame(8'hF0, 1'b1, -1, 4 * CLOCK_DIV + CLOCK_DIV / 2);
        check("mid_outputs_zero", 32'(snap_out), 32'h0);
        check("mid_state", 32'(snap_state), 32'(WAIT_IDLE));
        check("mid_no_push", 32'(not_empty), 32'h0);
        send_frame(8'h42, 1'b1, -1, -1);
        pop_check(8'h42, "mid_next_frame");
        check("mid_final_empty", 32'(not_empty), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
